// File: rtl/alu32_div_pkg.sv
// Shared definitions for the ALU32 iterative divider: FSM encoding and
// the divide-by-zero quotient fill.
package alu32_div_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Fill bit replicated to WIDTH: a divide by zero reports an all-ones quotient
    localparam logic DIVZERO_QUOT = 1'b1;

endpackage

// File: rtl/alu32_seq_divider_sub.sv
// WIDTH+1-bit subtractor (a + ~b + 1) for the divider trial step, built from
// 8-bit lookahead slices chained by slice carry plus a single top bit.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           no_borrow
);

    localparam int NSLICE = WIDTH / 8;

    logic [WIDTH:0]  b_inv_s;
    logic [NSLICE:0] slice_c_s;

    assign b_inv_s      = ~b;
    assign slice_c_s[0] = 1'b1;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        logic [7:0] g_s;
        logic [7:0] p_s;
        logic [8:0] c_s;

        assign g_s = a[8*k +: 8] & b_inv_s[8*k +: 8];
        assign p_s = a[8*k +: 8] ^ b_inv_s[8*k +: 8];

        // Flattened lookahead: every carry is a sum of generate terms gated by propagate runs
        always_comb begin
            logic acc_v;
            logic prop_v;
            c_s[0] = slice_c_s[k];
            for (int i = 0; i < 8; i++) begin
                acc_v  = g_s[i];
                prop_v = p_s[i];
                for (int j = i - 1; j >= 0; j--) begin
                    acc_v  = acc_v | (prop_v & g_s[j]);
                    prop_v = prop_v & p_s[j];
                end
                c_s[i+1] = acc_v | (prop_v & slice_c_s[k]);
            end
        end

        assign diff[8*k +: 8]  = p_s ^ c_s[7:0];
        assign slice_c_s[k+1]  = c_s[8];
    end

    assign diff[WIDTH] = a[WIDTH] ^ b_inv_s[WIDTH] ^ slice_c_s[NSLICE];
    assign no_borrow   = (a[WIDTH] & b_inv_s[WIDTH]) |
                         ((a[WIDTH] ^ b_inv_s[WIDTH]) & slice_c_s[NSLICE]);

endmodule

// File: rtl/alu32_seq_divider.sv
// Iterative restoring divider (one trial subtraction per clock) with signed
// and unsigned modes and a start/done handshake.
module alu32_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    import alu32_div_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             divzero_q, divzero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   trial_b_s;
    logic [WIDTH:0]   trial_diff_s;
    logic             no_borrow_s;
    logic             trial_ok_s;

    assign rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    assign trial_b_s   = {1'b0, dvs_q};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a         (rem_shift_s),
        .b         (trial_b_s),
        .diff      (trial_diff_s),
        .no_borrow (no_borrow_s)
    );

    // An accepted difference always fits back into the WIDTH-bit remainder
    assign trial_ok_s = no_borrow_s & ~trial_diff_s[WIDTH];

    // Next-state, datapath and output computation
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divzero_d   = divzero_q;
        // Status flags trail the state by one cycle
        busy_d      = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d  = ST_PREP;
                    quo_d    = Dividend;
                    dvs_d    = Divisor;
                    signed_d = Signed;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (dvs_q == {WIDTH{1'b0}}) begin
                    state_d     = ST_DONE;
                    quotient_d  = {WIDTH{DIVZERO_QUOT}};
                    remainder_d = quo_q;
                    divzero_d   = 1'b1;
                end else begin
                    neg_quo_d = signed_q & (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    neg_rem_d = signed_q & quo_q[WIDTH-1];
                    quo_d     = (signed_q && quo_q[WIDTH-1]) ? twos_neg(quo_q) : quo_q;
                    dvs_d     = (signed_q && dvs_q[WIDTH-1]) ? twos_neg(dvs_q) : dvs_q;
                    rem_d     = {WIDTH{1'b0}};
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                quo_d = {quo_q[WIDTH-2:0], trial_ok_s};
                rem_d = trial_ok_s ? trial_diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FIX: begin
                quotient_d  = neg_quo_q ? twos_neg(quo_q) : quo_q;
                remainder_d = neg_rem_q ? twos_neg(rem_q) : rem_q;
                divzero_d   = 1'b0;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            quo_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            signed_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            divzero_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divzero_q   <= divzero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivZero   = divzero_q;

endmodule

// File: tb/tb_alu32_seq_divider.sv
// Randomized and directed bench for alu32_seq_divider against an arithmetic
// reference model (truncating division on 64-bit integers).
module tb_alu32_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divzero;

    int checks = 0;
    int errors = 0;

    alu32_seq_divider #(.WIDTH(32)) dut (
        .CLK       (clk),
        .RST       (rst),
        .Start     (start),
        .Signed    (sgn),
        .Dividend  (dividend),
        .Divisor   (divisor),
        .Busy      (busy),
        .Done      (done),
        .Quotient  (quotient),
        .Remainder (remainder),
        .DivZero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: divide by zero rule, else truncating division on sign/zero-extended values
    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endtask

    // Entry and exit: 1 time unit after a rising edge
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          n;
        int          lat;
        int          busy_cnt;
        ref_div(s, a, b, eq, er, edz);
        start = 1'b1; sgn = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        n = 0; lat = -1; busy_cnt = 0;
        while (lat < 0 && n < 80) begin
            if (done) begin
                lat = n;
                check_val({tag, ".q"}, quotient, eq);
                check_val({tag, ".r"}, remainder, er);
                check_val({tag, ".dz"}, 32'(divzero), 32'(edz));
            end
            busy_cnt += int'(busy);
            if (n == pulse_at) begin
                start = 1'b1; sgn = 1'b1; dividend = 32'd5; divisor = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (lat < 0) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check_val({tag, ".latency"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd35);
        check_val({tag, ".busy_cycles"}, 32'(busy_cnt), (b == 32'd0) ? 32'd1 : 32'd34);
        start = 1'b0;
        @(posedge clk); #1;
        check_val({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_val({tag, ".hold_q"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          n;
        int          done_cnt;
        int          first_done;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.busy", 32'(busy), 32'd0);
        check_val("rst.done", 32'(done), 32'd0);
        check_val("rst.q", quotient, 32'd0);
        check_val("rst.r", remainder, 32'd0);
        check_val("rst.dz", 32'(divzero), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, -1);
        run_op("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, -1);
        run_op("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9, -1);
        run_op("divzero", 1'b0, 32'h0000_1234, 32'd0, -1);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, -1);
        run_op("ign_start", 1'b0, 32'd100, 32'd7, 10);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                rb = 32'($urandom_range(0, 15));
            end else if (sel == 1) begin
                rb = ~32'($urandom_range(0, 14));
            end else begin
                rb = $urandom;
            end
            run_op("rand", 1'($urandom_range(0, 1)), ra, rb, -1);
        end

        // Back-to-back: Start held high; operands changed mid-flight must not matter
        start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        dividend = 32'd9; divisor = 32'd3;
        n = 0; done_cnt = 0; first_done = -1;
        while (done_cnt < 2 && n < 120) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = n;
                    check_val("b2b.q1", quotient, 32'd14);
                    check_val("b2b.r1", remainder, 32'd2);
                end else begin
                    check_val("b2b.gap", 32'(n - first_done), 32'd35);
                    check_val("b2b.q2", quotient, 32'd3);
                    check_val("b2b.r2", remainder, 32'd0);
                end
            end
            if (done_cnt >= 1) start = 1'b0;
        end
        check_val("b2b.done_count", 32'(done_cnt), 32'd2);
        check_val("b2b.first_latency", 32'(first_done), 32'd35);
        start = 1'b0;
        @(posedge clk); #1;

        // Abort: RST sampled on edge 12 of a running operation
        start = 1'b1; sgn = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort.busy", 32'(busy), 32'd0);
        check_val("abort.done", 32'(done), 32'd0);
        check_val("abort.q", quotient, 32'd0);
        check_val("abort.r", remainder, 32'd0);
        check_val("abort.dz", 32'(divzero), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            done_cnt += int'(done) + int'(busy);
        end
        check_val("abort.no_done", 32'(done_cnt), 32'd0);
        run_op("after_abort", 1'b0, 32'd9, 32'd3, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
